hot_bits_serializer: RTL and testbench
======================================

Name: hot_bits_serializer

Overview:
- Sequential counterpart to the combinational one-hot decoder (position vector to binary index with no-hot and multi-hot error flags).
- Accepts a position vector with any number of hot bits over a valid/ready handshake. Emits the binary index of every set bit, one per beat, lowest index first.
- Multi-hot vectors are serialized instead of flagged. All-zero vectors are flagged and dropped.
- Sits between event/request vectors (interrupt lines, channel masks) and consumers that take one binary index at a time.

Parameters:
- BIN_WIDTH, 4, width of emitted binary index.
- POS_WIDTH, 2**BIN_WIDTH, width of input position vector. Derived; overriding it is not supported.

Ports:
- clk  input  1  clock, all logic on rising edge.
- nrst  input  1  asynchronous active-low reset.
- in_valid  input  1  in_pos is valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_pos  input  POS_WIDTH  position vector, bit i set means index i pending.
- out_valid  output  1  out_bin/out_last/out_beat are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_bin  output  BIN_WIDTH  index of the lowest pending set bit.
- out_last  output  1  current beat is the final set bit of the vector.
- out_beat  output  BIN_WIDTH+1  beat number within the vector, starting at 0.
- err_no_hot  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Reset (nrst low, async): state=IDLE, pending=0, out_beat=0, err_no_hot=0.
  - Hence out_valid=0, out_last=0, out_bin=0, in_ready=1.
  - Reset mid-vector discards all remaining bits. No beat is emitted after reset release until a new vector is accepted.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SCAN: out_valid=1.
- Accept = in_valid & in_ready, sampled on a clk edge:
  - in_pos==0: err_no_hot=1 for the following cycle only. State stays or becomes IDLE. Nothing is emitted.
  - in_pos!=0: pending<=in_pos, out_beat<=0, state<=SCAN.
- Latency: a vector accepted at edge N gives out_valid=1 in the cycle after edge N. One beat per cycle with out_ready held high.
- Outputs in SCAN:
  - out_bin = index of the lowest set bit of registered pending, via a priority encoder (lowest index wins).
  - out_last = (pending has exactly one bit set).
  - All outputs are driven from registered state only. They hold stable while out_valid=1 and out_ready=0.
- Beat handshake = out_valid & out_ready at an edge:
  - Clear the lowest set bit of pending.
  - out_beat increments.
  - If out_last: state<=IDLE, unless a new vector is accepted at the same edge.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
  - This is a combinational path from out_ready, intentional for back-to-back vectors with no bubble.
  - Simultaneous last beat and accept: the new vector loads and SCAN continues with out_beat=0. If the new vector is zero, err_no_hot pulses and state goes to IDLE.
- in_pos is ignored whenever in_ready=0. Upstream must hold in_pos/in_valid until accepted.
- Count bound: at most POS_WIDTH beats per vector. out_beat maximum is POS_WIDTH-1 (fits BIN_WIDTH+1 bits) and never wraps.
- out_valid never drops without a handshake, except on reset.

Test Plan:
- Single hot: in_pos=16'h0020 accepted at edge 0 -> cycle 1: out_valid=1, out_bin=5, out_last=1, out_beat=0. out_valid=0 after the handshake.
- Multi hot: in_pos=16'h8421, out_ready=1 -> out_bin 0,5,10,15 on consecutive cycles. out_beat 0..3. out_last only on 15.
- No hot: in_pos=0 accepted -> err_no_hot=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- Back-pressure: in_pos=16'h0006, out_ready=0 for 3 cycles -> out_bin=1, out_beat=0 held stable, in_ready=0. Then out_ready=1 -> beats 1 then 2.
- Back-to-back: 16'h0003 then 16'hFFFF presented with in_valid high, out_ready=1 -> 18 consecutive beats with no idle cycle. The second vector is accepted at the edge of beat index 1 (out_last). All 16 indices 0..15 are emitted in order.
- Reset mid-vector: in_pos=16'hFFFF, nrst driven low asynchronously after 3 beats -> out_valid=0 immediately. After release: idle, in_ready=1, no residual beats.

Source files
------------

// File: rtl/hot_bits_serializer.sv
// hot_bits_serializer
//
// Takes a position vector with any number of set bits. Emits the binary
// index of each set bit, one per beat and lowest index first. An all-zero
// vector is dropped and reported with a one-cycle err_no_hot pulse.
//
// Ports:
//   clk        clock; all logic is on the rising edge
//   nrst       asynchronous active-low reset
//   in_valid   in_pos is valid
//   in_ready   block can accept a vector this cycle
//   in_pos     position vector; bit i set means index i is pending
//   out_valid  out_bin/out_last/out_beat are valid
//   out_ready  consumer accepts the current beat
//   out_bin    index of the lowest pending set bit
//   out_last   current beat is the final set bit of the vector
//   out_beat   beat number within the vector, starting at 0
//   err_no_hot one-cycle pulse: an all-zero vector was accepted
//   dbg_state  FSM state (0 = IDLE, 1 = SCAN) for observation
//
// Handshake rule, used on both sides: a transfer happens on a rising edge
// where valid and ready are both high. A producer holds valid and its data
// stable until that edge and never drops valid without a transfer. Ready
// may depend on the other side's signals combinationally.

module hot_bits_serializer #(
    parameter int BIN_WIDTH = 4,
    parameter int POS_WIDTH = 2 ** BIN_WIDTH
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [POS_WIDTH-1:0] in_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIN_WIDTH-1:0] out_bin,
    output logic                 out_last,
    output logic [BIN_WIDTH:0]   out_beat,
    output logic                 err_no_hot,
    output logic                 dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e                 state_q;
    logic [POS_WIDTH-1:0]   pending_q;
    logic [POS_WIDTH-1:0]   pending_d;
    logic [BIN_WIDTH:0]     beat_q;
    logic                   err_q;

    logic [BIN_WIDTH-1:0]   low_idx;
    logic                   one_left;
    logic                   accept;
    logic                   beat_done;

    // pending minus its lowest set bit
    assign pending_d = pending_q & (pending_q - POS_WIDTH'(1));

    // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
    assign one_left  = (pending_q != '0) && (pending_d == '0);

    // Priority encoder: scan downward so the lowest set bit is written last.
    always_comb begin
        low_idx = '0;
        for (int i = POS_WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = BIN_WIDTH'(i);
            end
        end
    end

    assign out_valid  = (state_q == ST_SCAN);
    assign out_bin    = low_idx;
    assign out_last   = one_left;
    assign out_beat   = beat_q;
    assign err_no_hot = err_q;
    assign dbg_state  = state_q;

    assign beat_done  = out_valid & out_ready;
    // Ready during the final beat lets the next vector load with no bubble;
    // this is a deliberate combinational path from out_ready.
    assign in_ready   = (state_q == ST_IDLE) | (beat_done & one_left);
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept && (in_pos == '0);
            if (accept) begin
                // An accept wins over the final-beat return to IDLE.
                if (in_pos != '0) begin
                    pending_q <= in_pos;
                    beat_q    <= '0;
                    state_q   <= ST_SCAN;
                end else begin
                    pending_q <= '0;
                    state_q   <= ST_IDLE;
                end
            end else if (beat_done) begin
                pending_q <= pending_d;
                beat_q    <= beat_q + (BIN_WIDTH + 1)'(1);
                if (one_left) begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_hot_bits_serializer.sv
module tb_hot_bits_serializer;

  localparam int BW = 4;
  localparam int PW = 16;

  logic          clk;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pos;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_bin;
  logic          out_last;
  logic [BW:0]   out_beat;
  logic          err_no_hot;
  logic          dbg_state;

  hot_bits_serializer #(.BIN_WIDTH(BW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pos     (in_pos),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .out_beat   (out_beat),
    .err_no_hot (err_no_hot),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  // Each entry is one expected beat: {last, beat, bin}.
  logic [9:0] exp_q[$];
  logic       err_exp = 1'b0;
  int         acc_cnt = 0;

  initial begin
    logic [9:0] tmp;
    logic       m_ready;
    logic       acc;
    int         k;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        exp_q.delete();
        err_exp = 1'b0;
      end else begin
        m_ready = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
        acc = in_valid && m_ready;
        if (exp_q.size() != 0 && out_ready) tmp = exp_q.pop_front();
        if (acc) begin
          acc_cnt++;
          k = 0;
          for (int i = 0; i < PW; i++) begin
            if (in_pos[i]) begin
              tmp = {((in_pos >> (i + 1)) == 0), 5'(k), 4'(i)};
              exp_q.push_back(tmp);
              k++;
            end
          end
        end
        err_exp = acc && (in_pos == 0);
      end
    end
  end

  // ---------------- compare + beat log ----------------
  logic [9:0] log_q[$];
  int         log_cyc[$];

  always @(negedge clk) begin
    if (nrst) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready),
          32'((exp_q.size() == 0) || (out_ready && exp_q.size() == 1)));
      chk("err_no_hot", 32'(err_no_hot), 32'(err_exp));
      if (out_valid && exp_q.size() != 0)
        chk("beat_word", 32'({out_last, out_beat, out_bin}), 32'(exp_q[0]));
      if (out_valid && out_ready) begin
        log_q.push_back({out_last, out_beat, out_bin});
        log_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [PW-1:0] v);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    in_valid = 1'b1;
    in_pos = v;
    while (acc_cnt == start && n < 200) begin
      step();
      n++;
    end
    if (acc_cnt == start) chk("accept_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
    in_pos = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("idle_timeout", 32'(n), 32'd0);
    step();
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int bins_m[4];
    int b2b[18];
    bins_m = '{0, 5, 10, 15};

    nrst = 1'b0;
    in_valid = 1'b0;
    in_pos = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_beat", 32'(out_beat), 32'd0);
    chk("rst_err", 32'(err_no_hot), 32'd0);
    step();
    nrst = 1'b1;
    step();

    // single hot
    out_ready = 1'b1;
    send(16'h0020);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_bin", 32'(out_bin), 32'd5);
    chk("single_last", 32'(out_last), 32'd1);
    chk("single_beat", 32'(out_beat), 32'd0);
    step();
    chk("single_done", 32'(out_valid), 32'd0);
    wait_idle();

    // multi hot
    clear_log();
    send(16'h8421);
    wait_idle();
    chk("multi_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("multi_bin", 32'(log_q[i][3:0]), 32'(bins_m[i]));
      chk("multi_beat", 32'(log_q[i][8:4]), 32'(i));
      chk("multi_last", 32'(log_q[i][9]), 32'(i == 3));
    end

    // no hot
    send(16'h0000);
    chk("nohot_err", 32'(err_no_hot), 32'd1);
    chk("nohot_valid", 32'(out_valid), 32'd0);
    chk("nohot_ready", 32'(in_ready), 32'd1);
    step();
    chk("nohot_err_clear", 32'(err_no_hot), 32'd0);
    wait_idle();

    // back-pressure
    out_ready = 1'b0;
    clear_log();
    send(16'h0006);
    for (int i = 0; i < 3; i++) begin
      chk("bp_bin", 32'(out_bin), 32'd1);
      chk("bp_beat", 32'(out_beat), 32'd0);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    wait_idle();
    chk("bp_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("bp_word0", 32'(log_q[0]), 32'({1'b0, 5'd0, 4'd1}));
      chk("bp_word1", 32'(log_q[1]), 32'({1'b1, 5'd1, 4'd2}));
    end

    // back-to-back: 0x0003 then 0xFFFF, no idle cycle between
    clear_log();
    b2b[0] = 0;
    b2b[1] = 1;
    for (int i = 0; i < 16; i++) b2b[i + 2] = i;
    send(16'h0003);
    send(16'hFFFF);
    wait_idle();
    chk("b2b_count", 32'(log_q.size()), 32'd18);
    for (int i = 0; i < 18 && i < log_q.size(); i++) begin
      chk("b2b_bin", 32'(log_q[i][3:0]), 32'(b2b[i]));
      chk("b2b_gap", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
    end
    if (log_q.size() == 18) begin
      chk("b2b_beat15", 32'(log_q[17][8:4]), 32'd15);
      chk("b2b_last15", 32'(log_q[17][9]), 32'd1);
      chk("b2b_last1", 32'(log_q[1][9]), 32'd1);
    end

    // a few more vectors against the model, with stalls
    send(16'h8000);
    wait_idle();
    out_ready = 1'b0;
    send(16'hA5A5);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    wait_idle();

    // reset mid-vector
    clear_log();
    send(16'hFFFF);
    step();
    step();
    step();
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_beat", 32'(out_beat), 32'd0);
    @(posedge clk);
    #3;
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("postrst_valid", 32'(out_valid), 32'd0);
      chk("postrst_ready", 32'(in_ready), 32'd1);
    end
    chk("midrst_beats", 32'(log_q.size()), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
